multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  opcode, instr[6:0], from the instruction register.
- funct3  in  3  instr[14:12]; bit 0 selects beq (0) or bne (1).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; access completes in a cycle where it is 1.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  instruction and oldPC register enable.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  ALU op class: 00 = add, 01 = subtract/compare, 10 = decode funct fields.
- immsrc  out  3  immediate type: I = 000, S = 001, B = 010, J = 011, U = 100.
- illegal  out  1  sticky trap flag.
- state  out  4  current state encoding, for debug.

Function
REQ-002 Every output not listed for a state SHALL be 0 in that state, including all 2-bit and 3-bit fields.
REQ-003 immsrc SHALL be a combinational function of op in every state and SHALL be 000 for R-type and unknown opcodes.
REQ-004 The states and their encodings SHALL be: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, JALR = 11, UTYPE = 12, TRAP = 13.
REQ-005 FETCH: alu_src_b = 10 and result_src = 10.
- ir_write = pc_write = mem_ready.
- The state SHALL remain FETCH while mem_ready = 0 and go to DECODE otherwise.
REQ-006 DECODE: alu_src_a = 01 and alu_src_b = 01 (branch/JAL target into ALUOut).
- Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 or 0010111 -> UTYPE.
- Any other op -> TRAP.
REQ-007 MEMADR: alu_src_a = 10 and alu_src_b = 01. Next state is MEMREAD if op[5] = 0, else MEMWRITE.
REQ-008 MEMREAD: adr_src = 1. Holds until mem_ready = 1, then goes to MEMWB.
REQ-009 MEMWB: result_src = 01 and reg_write = 1. Next state is FETCH.
REQ-010 MEMWRITE: adr_src = 1 and mem_write = 1 (held high while waiting). Holds until mem_ready = 1, then goes to FETCH.
REQ-011 EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next state is ALUWB.
REQ-012 EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10. Next state is ALUWB.
REQ-013 ALUWB: reg_write = 1 with result_src = 00. Next state is FETCH.
REQ-014 BRANCH: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00.
- pc_write = zero XOR funct3[0].
- Next state is FETCH.
REQ-015 JAL: alu_src_a = 01, alu_src_b = 10, result_src = 00, pc_write = 1 (PC <- target; ALUOut <- oldPC + 4). Next state is ALUWB.
REQ-016 JALR: alu_src_a = 10 and alu_src_b = 01 (target into ALUOut). Next state is JAL.
REQ-017 UTYPE: alu_src_b = 01 and alu_op = 00.
- alu_src_a = 11 when op[5] = 1 (LUI), else 01 (AUIPC).
- Next state is ALUWB.
REQ-018 TRAP: illegal = 1 and all enables = 0. TRAP SHALL be left only by reset.
REQ-019 Cycle counts from FETCH to FETCH with mem_ready = 1 SHALL be:
- 5 for loads;
- 4 for stores, R-type, I-type, jal and U-type;
- 3 for branches;
- 5 for jalr.
REQ-020 Each cycle of mem_ready = 0 spent in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle.

Reset
REQ-021 When reset is asserted, the block SHALL asynchronously enter FETCH, clear illegal, and drive all outputs to the FETCH values from REQ-005.
REQ-022 Reset asserted mid-instruction, including during a pending MEMWRITE wait, SHALL drop mem_write and reg_write in the same cycle.
REQ-023 After reset is released, the first FETCH SHALL begin on the next rising clk edge.

Structure
REQ-024 A shared package SHALL hold:
- the state enum;
- the opcode constants;
- the immsrc, result_src, alu_src_a, alu_src_b and alu_op encodings.
REQ-025 The immediate-type decode SHALL be one instantiated sub-module, instrDec, which drives immsrc.
REQ-026 The state register SHALL be a single always_ff block, and next-state and output logic SHALL be always_comb blocks.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- lw (op = 0000011) with mem_ready low for 2 cycles in FETCH and 1 in MEMREAD -> 8 cycles total; reg_write pulses once in MEMWB with result_src = 01.
- sw (op = 0100011), mem_ready = 1 -> mem_write high for exactly 1 cycle with adr_src = 1; reg_write never asserts.
- beq (funct3 = 000) with zero = 1 -> pc_write = 1 in BRANCH; bne (funct3 = 001) with zero = 1 -> pc_write = 0; both take 3 cycles.
- jalr (op = 1100111) -> state sequence 0, 1, 11, 10, 8, 0; pc_write high in FETCH and JAL only.
- op = 1111111 -> TRAP (state = 13) with illegal = 1 held for 20 cycles; reset returns state to 0 with illegal = 0.
- reset asserted mid-clock during a MEMWRITE wait -> mem_write = 0 before the next edge and state = 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package multicycle_ctrl_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned IMM_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UTYPE    = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_instrdec.sv
// Immediate-type decode; purely a function of the opcode, independent of FSM state.
module multicycle_ctrl_instrdec
    import multicycle_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [IMM_W-1:0] immsrc
);

    always_comb begin
        immsrc = IMM_I;
        case (op)
            OP_STORE:          immsrc = IMM_S;
            OP_BRANCH:         immsrc = IMM_B;
            OP_JAL:            immsrc = IMM_J;
            OP_LUI, OP_AUIPC:  immsrc = IMM_U;
            default:           immsrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: state register, next-state logic and
// state-decoded datapath controls.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                ir_write,
    output logic                mem_write,
    output logic                reg_write,
    output logic [SEL_W-1:0]    result_src,
    output logic [SEL_W-1:0]    alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    alu_op,
    output logic [IMM_W-1:0]    immsrc,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    state_e state_q;
    state_e state_d;

    logic unused_funct3;
    assign unused_funct3 = ^funct3[FUNCT3_W-1:1];

    multicycle_ctrl_instrdec instrDec (
        .op     (op),
        .immsrc (immsrc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = STATE_W'(state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_UTYPE:    state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Controls decode from the state register so an async reset clears them at once.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                pc_write  = zero ^ funct3[0];
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_UTYPE: begin
                alu_src_a = op[5] ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_TRAP:     illegal = 1'b1;
            default:    illegal = 1'b1;
        endcase
    end

endmodule
